// File: rtl/iram_loader_if.sv
// iram_loader_if: bundles the FIFO read side, the IRAM write port and the
// loader status lines between iram_loader and its surroundings.
// Ports: rx_empty/r_data/rd_uart (FIFO), iram_wa/iram_wen/iram_din (IRAM),
//        busy/done/err/words_loaded (status to top level).
// Modports: master = loader side, slave = FIFO/IRAM/top-level side.
interface iram_loader_if #(
  parameter int WIDTH          = 16,
  parameter int IRAM_ADDR_BITS = 8
);
  logic                      rx_empty;
  logic [7:0]                r_data;
  logic                      rd_uart;
  logic [IRAM_ADDR_BITS-1:0] iram_wa;
  logic                      iram_wen;
  logic [WIDTH-1:0]          iram_din;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic [8:0]                words_loaded;

  modport master (
    input  rx_empty, r_data,
    output rd_uart, iram_wa, iram_wen, iram_din, busy, done, err, words_loaded
  );

  modport slave (
    output rx_empty, r_data,
    input  rd_uart, iram_wa, iram_wen, iram_din, busy, done, err, words_loaded
  );
endinterface

// File: rtl/iram_loader.sv
// iram_loader: framed UART byte stream (sync, count, big-endian words,
// optional checksum) to IRAM writer; holds the CPU via busy during a frame.
// Latency: LO byte popped at t -> iram_wen at t+1, words_loaded at t+2.
// Backpressure: pops only when rx_empty=0, at most one byte per 2 cycles;
// an empty FIFO just stalls the frame until TIMEOUT idle cycles elapse.
// Ports: clk, reset (async, active-high); bus (iram_loader_if.master).
// Option: define IRAM_LOADER_CHECKSUM_EN to require and check a trailing
// modulo-256 sum of all data bytes.
module iram_loader #(
  parameter int         WIDTH          = 16,
  parameter int         IRAM_ADDR_BITS = 8,
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  parameter int         TIMEOUT        = 1000000
) (
  input logic           clk,
  input logic           reset,
  iram_loader_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WR,
`ifdef IRAM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_pop_prev;
  logic [7:0]                r_hi;
  logic [7:0]                r_lo;
  logic [IRAM_ADDR_BITS-1:0] r_addr;
  logic [8:0]                r_n;
  logic [8:0]                r_words;
  logic                      r_err;
  logic [TW-1:0]             r_tmo;
`ifdef IRAM_LOADER_CHECKSUM_EN
  logic [7:0]                r_csum;
`endif

  logic             w_in_frame;
  logic             w_can_pop;
  logic             w_pop;
  logic             w_sync;
  logic             w_tmo;
  logic             w_wen;
  logic             w_done;
  logic [WIDTH-1:0] w_din;

  // The write cycle and the checksum wait still count as "in frame" so the
  // idle-gap timer keeps running across them.
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_HI) ||
                      (r_state == S_LO)  || (r_state == S_WR)
`ifdef IRAM_LOADER_CHECKSUM_EN
                      || (r_state == S_CSUM)
`endif
                      ;

  // DONE/ERR do not pop, so a following sync byte is never swallowed there.
  assign w_can_pop = (r_state == S_IDLE) || (w_in_frame && (r_state != S_WR));

  // reset gates the strobe so no pop leaks out while reset is held.
  assign w_pop  = !reset && w_can_pop && !bus.rx_empty && !r_pop_prev;
  assign w_sync = (r_state == S_IDLE) && w_pop && (bus.r_data == SYNC_BYTE);

  // r_tmo holds cycles since the last consumed byte; leaving on TIMEOUT-1
  // makes err visible exactly TIMEOUT cycles after that byte.
  assign w_tmo = w_in_frame && !w_pop && (r_tmo == TW'(TIMEOUT - 1));

  assign w_din = {r_hi, r_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_wen  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (w_sync) w_next = S_LEN;
      S_LEN:  if (w_pop)  w_next = S_HI;
      S_HI:   if (w_pop)  w_next = S_LO;
      S_LO:   if (w_pop)  w_next = S_WR;
      S_WR: begin
        w_wen = 1'b1;
        if (r_words + 9'd1 == r_n) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_HI;
        end
      end
`ifdef IRAM_LOADER_CHECKSUM_EN
      S_CSUM: if (w_pop) w_next = (bus.r_data == r_csum) ? S_DONE : S_ERR;
`endif
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_tmo) w_next = S_ERR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pop_prev <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_addr     <= '0;
      r_n        <= '0;
      r_words    <= '0;
      r_err      <= 1'b0;
      r_tmo      <= '0;
`ifdef IRAM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_pop_prev <= w_pop;

      if (w_pop)           r_tmo <= TW'(1);
      else if (w_in_frame) r_tmo <= r_tmo + TW'(1);
      else                 r_tmo <= '0;

      if (w_next == S_ERR) r_err <= 1'b1;

      case (r_state)
        S_IDLE: if (w_sync) begin
          r_err   <= 1'b0;
          r_words <= '0;
          r_addr  <= '0;
`ifdef IRAM_LOADER_CHECKSUM_EN
          r_csum  <= '0;
`endif
        end
        // A count byte of 0 stands for 256 words.
        S_LEN: if (w_pop) r_n <= {(bus.r_data == 8'd0), bus.r_data};
        S_HI: if (w_pop) begin
          r_hi   <= bus.r_data;
`ifdef IRAM_LOADER_CHECKSUM_EN
          r_csum <= r_csum + bus.r_data;
`endif
        end
        S_LO: if (w_pop) begin
          r_lo   <= bus.r_data;
`ifdef IRAM_LOADER_CHECKSUM_EN
          r_csum <= r_csum + bus.r_data;
`endif
        end
        // Address wraps silently at the IRAM depth.
        S_WR: begin
          r_addr  <= r_addr + IRAM_ADDR_BITS'(1);
          r_words <= r_words + 9'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_uart      = w_pop;
  assign bus.iram_wa      = r_addr;
  assign bus.iram_wen     = w_wen;
  assign bus.iram_din     = w_din;
  assign bus.busy         = w_in_frame;
  assign bus.done         = w_done;
  assign bus.err          = r_err;
  assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_iram_loader.sv
// tb_iram_loader: random framed byte streams through a FIFO model into
// iram_loader; a frame-level reference model predicts IRAM writes and
// frame-end events, and a negedge monitor checks them as they appear.
module tb_iram_loader;
  localparam int         AB    = 4;
  localparam int         DEPTH = 1 << AB;
  localparam int         TMO   = 100;
  localparam logic [7:0] SYNC  = 8'h55;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iram_loader_if #(.WIDTH(16), .IRAM_ADDR_BITS(AB)) bus ();

  iram_loader #(
    .WIDTH(16), .IRAM_ADDR_BITS(AB), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { logic [AB-1:0] addr; logic [15:0] data; } wr_t;
  typedef struct { bit is_err; int words; int gap; } ev_t;

  wr_t         exp_wr[$];
  ev_t         exp_ev[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  junk_q[$];
  logic [15:0] word_q[$];
  logic [15:0] mem_dut   [0:DEPTH-1];
  logic [15:0] mem_model [0:DEPTH-1];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          no_stall = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  // FIFO model: first-word fall-through, random empty gaps unless no_stall.
  bit popped;
  bit stall;
  initial begin
    bus.rx_empty = 1'b1;
    bus.r_data   = 8'h00;
    forever begin
      @(negedge clk);
      popped = bus.rd_uart;
      @(posedge clk);
      #1;
      if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
      stall = !no_stall && ($urandom_range(0, 9) < 3);
      if (fifo_q.size() == 0 || stall) begin
        bus.rx_empty = 1'b1;
      end else begin
        bus.rx_empty = 1'b0;
        bus.r_data   = fifo_q[0];
      end
    end
  end

  // Monitor / scoreboard.
  int  cyc = 0;
  int  last_pop = 0;
  bit  prev_pop = 1'b0;
  bit  prev_err = 1'b0;
  bit  prev_busy = 1'b0;
  wr_t mw;
  ev_t me;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (bus.rd_uart) begin
          chk("pop_spacing", 32'(prev_pop), 0);
          last_pop = cyc;
        end
        if (bus.iram_wen) begin
          if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            mw = exp_wr.pop_front();
            chk("wr_addr", 32'(bus.iram_wa), 32'(mw.addr));
            chk("wr_data", 32'(bus.iram_din), 32'(mw.data));
          end
          mem_dut[bus.iram_wa] = bus.iram_din;
        end
        if (bus.done || (bus.err && !prev_err)) begin
          if (exp_ev.size() == 0) chk("unexpected_frame_end", 1, 0);
          else begin
            me = exp_ev.pop_front();
            chk("end_err", 32'(bus.err), 32'(me.is_err));
            chk("end_done", 32'(bus.done), 32'(!me.is_err));
            chk("end_words", 32'(bus.words_loaded), me.words);
            chk("end_gap", cyc - last_pop, me.gap);
            chk("end_busy", 32'(bus.busy), 0);
          end
        end
        if (bus.busy && !prev_busy) begin
          chk("start_err_clear", 32'(bus.err), 0);
          chk("start_words_clear", 32'(bus.words_loaded), 0);
        end
      end
      prev_pop  = bus.rd_uart;
      prev_err  = bus.err;
      prev_busy = bus.busy;
    end
  end

  // Reference model: builds the byte stream of one frame and predicts its
  // writes and end event. trunc>=0 delivers only that many bytes after sync.
  task automatic send_frame(input bit bad_csum, input int trunc, input bit expect_end);
    logic [7:0] fb[$];
    logic [7:0] sum;
    logic [7:0] cbyte;
    int         n, written, keep;
    wr_t        w;
    ev_t        e;
    n   = word_q.size();
    sum = 8'h00;
    fb  = junk_q;
    fb.push_back(SYNC);
    fb.push_back(8'(n % 256));
    foreach (word_q[i]) begin
      fb.push_back(word_q[i][15:8]);
      fb.push_back(word_q[i][7:0]);
      sum = sum + word_q[i][15:8] + word_q[i][7:0];
    end
`ifdef IRAM_LOADER_CHECKSUM_EN
    cbyte = bad_csum ? ~sum : sum;
    fb.push_back(cbyte);
`else
    cbyte = sum;
`endif
    written = n;
    if (trunc >= 0) begin
      keep = junk_q.size() + 1 + trunc;
      while (fb.size() > keep) void'(fb.pop_back());
      written = (trunc >= 1) ? (trunc - 1) / 2 : 0;
      if (written > n) written = n;
    end
    for (int i = 0; i < written; i++) begin
      w.addr = AB'(i);
      w.data = word_q[i];
      exp_wr.push_back(w);
      mem_model[i % DEPTH] = word_q[i];
    end
    if (expect_end) begin
      e.words = written;
      if (trunc >= 0) begin
        e.is_err = 1'b1;
        e.gap    = TMO;
      end else begin
`ifdef IRAM_LOADER_CHECKSUM_EN
        e.is_err = bad_csum;
        e.gap    = 1;
`else
        e.is_err = 1'b0;
        e.gap    = 2;
`endif
      end
      exp_ev.push_back(e);
    end
    foreach (fb[i]) fifo_q.push_back(fb[i]);
  endtask

  task automatic fill_words(input int n);
    word_q = {};
    for (int i = 0; i < n; i++) word_q.push_back(16'($urandom));
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || exp_ev.size() != 0 || exp_wr.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (k >= budget) begin
      chk("wait_idle_timeout", 1, 0);
      exp_ev.delete();
      exp_wr.delete();
      fifo_q.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_err"},   32'(bus.err), 0);
    chk({tag, "_rd"},    32'(bus.rd_uart), 0);
    chk({tag, "_wen"},   32'(bus.iram_wen), 0);
    chk({tag, "_words"}, 32'(bus.words_loaded), 0);
    chk({tag, "_wa"},    32'(bus.iram_wa), 0);
    chk({tag, "_din"},   32'(bus.iram_din), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  int         n, tr, nj;
  bit         bad;
  logic [7:0] b;
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_dut[i]   = 16'h0000;
      mem_model[i] = 16'h0000;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Reference frame from the examples (checksum computed from the rule).
    junk_q = {};
    word_q = {16'h1234, 16'hABCD};
    send_frame(1'b0, -1, 1'b1);
    wait_idle(2000);

`ifdef IRAM_LOADER_CHECKSUM_EN
    // Same words, corrupted checksum: words land, err, no done.
    send_frame(1'b1, -1, 1'b1);
    wait_idle(2000);
`endif

    // Leading junk discarded.
    junk_q = {8'h00, 8'hFF};
    word_q = {16'h0007};
    send_frame(1'b0, -1, 1'b1);
    wait_idle(2000);
    junk_q = {};

    // Stall after 55 03 12 -> timeout error.
    word_q = {16'h12AA, 16'h0000, 16'h0000};
    send_frame(1'b0, 2, 1'b1);
    wait_idle(2000);

    // Back-to-back FIFO.
    no_stall = 1'b1;
    fill_words(6);
    send_frame(1'b0, -1, 1'b1);
    wait_idle(2000);
    no_stall = 1'b0;

    // Count byte 0 = 256 words; address wraps many times.
    fill_words(256);
    send_frame(1'b0, -1, 1'b1);
    wait_idle(6000);

    // Random frames with junk, bad checksums and truncations.
    for (int f = 0; f < 8; f++) begin
      junk_q = {};
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        junk_q.push_back(b);
      end
      n = $urandom_range(1, 40);
      fill_words(n);
      bad = ($urandom_range(0, 3) == 0);
      tr  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2 * n - 1)) : -1;
      send_frame(bad, tr, 1'b1);
      wait_idle(3000);
    end
    junk_q = {};

    // Reset during the HI byte of word 1.
    word_q = {16'hC0DE, 16'h1111, 16'h2222};
    send_frame(1'b0, 4, 1'b0);
    for (int k = 0; k < 200 && fifo_q.size() != 0; k++) @(posedge clk);
    chk("reset_frame_drained", fifo_q.size(), 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    chk("iram0_kept", 32'(mem_dut[0]), 32'h0000C0DE);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_wr.delete();
    word_q = {16'hBEEF};
    send_frame(1'b0, -1, 1'b1);
    wait_idle(2000);

    chk("leftover_writes", exp_wr.size(), 0);
    chk("leftover_events", exp_ev.size(), 0);
    for (int i = 0; i < DEPTH; i++) chk("iram_content", 32'(mem_dut[i]), 32'(mem_model[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
